// File: rtl/sobel_window_stage_pkg.sv
// Shared definitions for the Sobel window stage.
//   WIN_DIM / WIN_ELEMS : 3x3 window geometry
//   SOBEL_MID_SHIFT     : the centre tap of each Sobel row/column has weight 2 (a left shift by 1)
//   trk_state_t         : position tracker FSM states
//   win_idx(i,j)        : flat element index of window element (i,j), i = row (0 = bottom),
//                         j = column (0 = right)
//   coord_bits(n)       : width of a coordinate counter that spans 0..n-1
package sobel_window_stage_pkg;

   localparam int WIN_DIM         = 3;
   localparam int WIN_ELEMS       = WIN_DIM * WIN_DIM;
   localparam int SOBEL_MID_SHIFT = 1;

   typedef enum logic {
      TRK_IDLE   = 1'b0,
      TRK_ACTIVE = 1'b1
   } trk_state_t;

   function automatic int win_idx(input int i, input int j);
      return i * WIN_DIM + j;
   endfunction

   function automatic int coord_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sobel_window_stage_tracker.sv
// window_pos_tracker: follows the raster position of the pixel stream that feeds the window
// generator and decides which windows are fully inside the frame.
//   clk, rst_n      : clock, asynchronous active-low reset
//   pix_valid       : a pixel is pushed into the generator this cycle
//   pix_sof         : that pixel is the first of a frame (only meaningful with pix_valid)
//   accept          : registered; the window the generator presents next cycle is interior
//   cx, cy          : registered centre coordinate of that window
//   eof             : registered; the accepted window is the last one of the frame
//   frame_err       : registered one-cycle pulse, pix_valid dropped inside an active frame
//
// Stream handshake: pix_valid qualifies pix_sof for one cycle; there is no ready, every valid
// pixel is taken on the edge where it is presented, and inside a frame one pixel must arrive
// on every clock.
module window_pos_tracker
   import sobel_window_stage_pkg::*;
#(
   parameter int frameW = 640,
   parameter int frameH = 480,
   parameter int XW     = coord_bits(frameW),
   parameter int YW     = coord_bits(frameH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pix_valid,
   input  logic          pix_sof,
   output logic          accept,
   output logic [XW-1:0] cx,
   output logic [YW-1:0] cy,
   output logic          eof,
   output logic          frame_err
);

   trk_state_t    state_q, state_d;
   // x_q/y_q hold the position the NEXT pixel of the frame will occupy
   logic [XW-1:0] x_q, x_d, px;
   logic [YW-1:0] y_q, y_d, py;
   logic          push;
   logic          err_d;
   logic          acc_d;
   logic          eof_d;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      px      = '0;
      py      = '0;
      push    = 1'b0;
      err_d   = 1'b0;
      if (pix_valid && pix_sof) begin
         // start of frame wins in any state: this pixel is (0,0)
         push    = 1'b1;
         state_d = TRK_ACTIVE;
         x_d     = XW'(1);
         y_d     = '0;
      end else if (state_q == TRK_ACTIVE) begin
         if (pix_valid) begin
            push = 1'b1;
            px   = x_q;
            py   = y_q;
            if (x_q == XW'(frameW - 1)) begin
               x_d = '0;
               if (y_q == YW'(frameH - 1)) begin
                  y_d     = '0;
                  state_d = TRK_IDLE;
               end else begin
                  y_d = y_q + 1'b1;
               end
            end else begin
               x_d = x_q + 1'b1;
            end
         end else begin
            // the generator kept shifting, so window contents are no longer a valid raster
            err_d   = 1'b1;
            state_d = TRK_IDLE;
            x_d     = '0;
            y_d     = '0;
         end
      end
      acc_d = push && (px >= XW'(2)) && (py >= YW'(2));
      eof_d = push && (px == XW'(frameW - 1)) && (py == YW'(frameH - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= TRK_IDLE;
         x_q       <= '0;
         y_q       <= '0;
         accept    <= 1'b0;
         cx        <= '0;
         cy        <= '0;
         eof       <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         accept    <= acc_d;
         cx        <= px - 1'b1;
         cy        <= py - 1'b1;
         eof       <= eof_d;
         frame_err <= err_d;
      end
   end

endmodule

// File: rtl/sobel_window_stage.sv
// sobel_window_stage: consumes the 3x3 window generator output, keeps only interior windows
// and produces a pipelined, saturated Sobel magnitude |Gx|+|Gy| per interior pixel.
//   clk, rst_n : clock, asynchronous active-low reset
//   pix_valid  : pixel pushed into the window generator this cycle
//   pix_sof    : first pixel of frame (with pix_valid)
//   Window     : 3x3 window, element k = i*3+j at bits [dataDept*k +: dataDept]
//   out_valid  : result valid (no backpressure, one result per clock)
//   out_pix    : saturated magnitude
//   out_x/out_y: centre coordinate of the result
//   out_eof    : last result of the frame
//   frame_err  : one-cycle pulse on a pix_valid gap inside a frame
// Timing: a pixel taken on edge N yields a window that is sampled on N+1, weighted sums on N+2,
// Gx/Gy on N+3 and the registered result on N+4.
module sobel_window_stage
   import sobel_window_stage_pkg::*;
#(
   parameter int dataDept  = 8,
   parameter int frameW    = 640,
   parameter int frameH    = 480,
   parameter int MAG_SHIFT = 0,
   localparam int XW       = coord_bits(frameW),
   localparam int YW       = coord_bits(frameH)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          pix_valid,
   input  logic                          pix_sof,
   input  logic [WIN_ELEMS*dataDept-1:0] Window,
   output logic                          out_valid,
   output logic [dataDept-1:0]           out_pix,
   output logic [XW-1:0]                 out_x,
   output logic [YW-1:0]                 out_y,
   output logic                          out_eof,
   output logic                          frame_err
);

   localparam int PW = dataDept + 2;   // one weighted 1-2-1 sum
   localparam int SW = dataDept + 4;   // signed gradient and unsigned magnitude

   logic          trk_acc;
   logic          trk_eof;
   logic          trk_err;
   logic [XW-1:0] trk_x;
   logic [YW-1:0] trk_y;

   window_pos_tracker #(
      .frameW (frameW),
      .frameH (frameH),
      .XW     (XW),
      .YW     (YW)
   ) u_tracker (
      .clk       (clk),
      .rst_n     (rst_n),
      .pix_valid (pix_valid),
      .pix_sof   (pix_sof),
      .accept    (trk_acc),
      .cx        (trk_x),
      .cy        (trk_y),
      .eof       (trk_eof),
      .frame_err (trk_err)
   );

   function automatic logic [PW-1:0] wsum(input logic [dataDept-1:0] a,
                                          input logic [dataDept-1:0] m,
                                          input logic [dataDept-1:0] b);
      return PW'(a) + (PW'(m) << SOBEL_MID_SHIFT) + PW'(b);
   endfunction

   // window sample: one edge after the tracker decided, matching the generator's capture
   logic                          v0, e0;
   logic [XW-1:0]                 x0;
   logic [YW-1:0]                 y0;
   logic [WIN_ELEMS*dataDept-1:0] win0;
   logic [dataDept-1:0]           w [WIN_ELEMS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0   <= 1'b0;
         e0   <= 1'b0;
         x0   <= '0;
         y0   <= '0;
         win0 <= '0;
      end else begin
         v0 <= trk_acc;
         e0 <= trk_eof;
         x0 <= trk_x;
         y0 <= trk_y;
         if (trk_acc) win0 <= Window;
      end
   end

   always_comb begin
      for (int k = 0; k < WIN_ELEMS; k++) w[k] = win0[dataDept*k +: dataDept];
   end

   // S1: column j=0 is the right (newer) column, row i=0 the bottom (newer) row
   logic          v1, e1;
   logic [XW-1:0] x1;
   logic [YW-1:0] y1;
   logic [PW-1:0] gxp, gxn, gyp, gyn;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1  <= 1'b0;
         e1  <= 1'b0;
         x1  <= '0;
         y1  <= '0;
         gxp <= '0;
         gxn <= '0;
         gyp <= '0;
         gyn <= '0;
      end else begin
         v1  <= v0;
         e1  <= e0;
         x1  <= x0;
         y1  <= y0;
         gxp <= wsum(w[win_idx(0,0)], w[win_idx(1,0)], w[win_idx(2,0)]);
         gxn <= wsum(w[win_idx(0,2)], w[win_idx(1,2)], w[win_idx(2,2)]);
         gyp <= wsum(w[win_idx(0,0)], w[win_idx(0,1)], w[win_idx(0,2)]);
         gyn <= wsum(w[win_idx(2,0)], w[win_idx(2,1)], w[win_idx(2,2)]);
      end
   end

   // S2: signed gradients
   logic                 v2, e2;
   logic [XW-1:0]        x2;
   logic [YW-1:0]        y2;
   logic signed [SW-1:0] gx, gy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2 <= 1'b0;
         e2 <= 1'b0;
         x2 <= '0;
         y2 <= '0;
         gx <= '0;
         gy <= '0;
      end else begin
         v2 <= v1;
         e2 <= e1;
         x2 <= x1;
         y2 <= y1;
         gx <= $signed({2'b00, gxp}) - $signed({2'b00, gxn});
         gy <= $signed({2'b00, gyp}) - $signed({2'b00, gyn});
      end
   end

   // S3: magnitude, scale, saturate. |Gx|+|Gy| <= 8*(2^dataDept-1) so SW bits never overflow.
   logic [SW-1:0]       ax, ay, asum, mag;
   logic [dataDept-1:0] sat;

   always_comb begin
      ax   = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
      ay   = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);
      asum = ax + ay;
      mag  = asum >> MAG_SHIFT;
      sat  = (|mag[SW-1:dataDept]) ? '1 : mag[dataDept-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_pix   <= '0;
         out_x     <= '0;
         out_y     <= '0;
         out_eof   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         out_valid <= v2;
         out_pix   <= sat;
         out_x     <= x2;
         out_y     <= y2;
         out_eof   <= e2 & v2;
         frame_err <= trk_err;
      end
   end

endmodule

// File: tb/tb_sobel_window_stage.sv
// Bench for sobel_window_stage on an 8x6 frame with a behavioural 3x3 window generator in front.
// Two instances share the stream: MAG_SHIFT=0 and MAG_SHIFT=2.
module tb_sobel_window_stage;

   localparam int DW  = 8;
   localparam int FW  = 8;
   localparam int FH  = 6;
   localparam int XW  = 3;
   localparam int YW  = 3;
   localparam int EW  = XW + YW + 1;
   localparam int RW  = EW + DW + 1;
   localparam int SRN = 2 * FW + 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pix_valid;
   logic          pix_sof;
   logic [DW-1:0] in_data;
   logic [DW-1:0] sr [SRN];
   logic [9*DW-1:0] window;

   logic          out_valid, out_eof, frame_err;
   logic [DW-1:0] out_pix;
   logic [XW-1:0] out_x;
   logic [YW-1:0] out_y;
   logic          s_out_valid, s_out_eof, s_frame_err;
   logic [DW-1:0] s_out_pix;
   logic [XW-1:0] s_out_x;
   logic [YW-1:0] s_out_y;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int err_cnt  = 0;
   int r_x[$], r_y[$], r_pix[$], r_eof[$], r_cyc[$];
   logic [RW-1:0] r2_q[$];
   logic [EW-1:0] exp_q[$];

   // ---------------- clock / generator / DUTs ----------------
   always #5 clk = ~clk;

   always @(posedge clk) begin
      for (int k = SRN - 1; k > 0; k--) sr[k] <= sr[k-1];
      sr[0] <= in_data;
   end

   always_comb begin
      window = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            window[DW*(i*3+j) +: DW] = sr[i*FW+j];
   end

   sobel_window_stage #(.dataDept(DW), .frameW(FW), .frameH(FH), .MAG_SHIFT(0)) dut (
      .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_sof(pix_sof), .Window(window),
      .out_valid(out_valid), .out_pix(out_pix), .out_x(out_x), .out_y(out_y),
      .out_eof(out_eof), .frame_err(frame_err));

   sobel_window_stage #(.dataDept(DW), .frameW(FW), .frameH(FH), .MAG_SHIFT(2)) dut_s2 (
      .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_sof(pix_sof), .Window(window),
      .out_valid(s_out_valid), .out_pix(s_out_pix), .out_x(s_out_x), .out_y(s_out_y),
      .out_eof(s_out_eof), .frame_err(s_frame_err));

   // ---------------- result capture (away from the active edge) ----------------
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (out_valid) begin
         r_x.push_back(int'(out_x));
         r_y.push_back(int'(out_y));
         r_pix.push_back(int'(out_pix));
         r_eof.push_back(int'(out_eof));
         r_cyc.push_back(cyc);
      end
      if (s_out_valid) r2_q.push_back({s_frame_err, s_out_eof, s_out_y, s_out_x, s_out_pix});
      if (frame_err) err_cnt++;
   end

   // ---------------- drivers and expected-list builders ----------------
   task automatic push(input logic v, input logic s, input int d);
      pix_valid = v;
      pix_sof   = s;
      in_data   = DW'(d);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) push(1'b0, 1'b0, 0);
   endtask

   function automatic int pixval(input int pat, input int x);
      case (pat)
         0:       return 100;
         1:       return (x < 4) ? 0 : 255;
         default: return 10 * x;
      endcase
   endfunction

   // Drives a frame in raster order; stops before (stop_x,stop_y), optionally with a gap cycle.
   task automatic send_frame(input int pat, input int stop_x, input int stop_y, input bit gap,
                             output int acc_cyc);
      acc_cyc = -1;
      for (int y = 0; y < FH; y++) begin
         for (int x = 0; x < FW; x++) begin
            if (x == stop_x && y == stop_y) begin
               if (gap) push(1'b0, 1'b0, 0);
               return;
            end
            push(1'b1, (x == 0 && y == 0), pixval(pat, x));
            if (x == 2 && y == 2) acc_cyc = cyc;
         end
      end
   endtask

   task automatic add_c(input int x, input int y, input bit e);
      exp_q.push_back({e, YW'(y), XW'(x)});
   endtask

   task automatic add_full();
      for (int y = 1; y <= FH - 2; y++)
         for (int x = 1; x <= FW - 2; x++)
            add_c(x, y, (x == FW - 2 && y == FH - 2));
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; in_data = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      checks++; if (out_pix !== '0) begin failures++; $display("FAIL reset_pix got=%0d exp=0", out_pix); end
      checks++; if (out_x !== '0 || out_y !== '0) begin failures++; $display("FAIL reset_xy got=(%0d,%0d) exp=(0,0)", out_x, out_y); end
      checks++; if (out_eof !== 1'b0) begin failures++; $display("FAIL reset_eof got=%b exp=0", out_eof); end
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", frame_err); end
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_flat();
      int base, acc, n, m, first;
      logic [EW-1:0] e;
      exp_q.delete(); add_full();
      base = r_x.size();
      send_frame(0, -1, -1, 1'b0, acc);
      idle(8);
      n = r_x.size() - base;
      m = (n < exp_q.size()) ? n : exp_q.size();
      checks++; if (n !== exp_q.size()) begin failures++; $display("FAIL flat_count got=%0d exp=%0d", n, exp_q.size()); end
      first = (n > 0) ? r_cyc[base] : -1;
      checks++; if (first !== acc + 4) begin failures++; $display("FAIL flat_latency got=%0d exp=%0d", first, acc + 4); end
      for (int k = 0; k < m; k++) begin
         e = exp_q[k];
         checks++;
         if (r_x[base+k] !== int'(e[XW-1:0]) || r_y[base+k] !== int'(e[EW-2:XW]) ||
             r_eof[base+k] !== int'(e[EW-1]) || r_pix[base+k] !== 0) begin
            failures++;
            $display("FAIL flat_res k=%0d got=(%0d,%0d) pix=%0d eof=%0d exp=(%0d,%0d) pix=0 eof=%0d",
                     k, r_x[base+k], r_y[base+k], r_pix[base+k], r_eof[base+k], e[XW-1:0], e[EW-2:XW], e[EW-1]);
         end
      end
   endtask

   task automatic test_vstep();
      int base, base2, acc, n, m, ep;
      logic [EW-1:0] e;
      logic [RW-1:0] e2;
      exp_q.delete(); add_full();
      base = r_x.size(); base2 = r2_q.size();
      send_frame(1, -1, -1, 1'b0, acc);
      idle(8);
      n = r_x.size() - base;
      m = (n < exp_q.size()) ? n : exp_q.size();
      checks++; if (n !== exp_q.size()) begin failures++; $display("FAIL vstep_count got=%0d exp=%0d", n, exp_q.size()); end
      checks++; if (r2_q.size() - base2 !== exp_q.size()) begin failures++; $display("FAIL vstep_count_s2 got=%0d exp=%0d", r2_q.size() - base2, exp_q.size()); end
      for (int k = 0; k < m; k++) begin
         e  = exp_q[k];
         ep = (e[XW-1:0] == 3 || e[XW-1:0] == 4) ? 255 : 0;
         checks++;
         if (r_x[base+k] !== int'(e[XW-1:0]) || r_y[base+k] !== int'(e[EW-2:XW]) ||
             r_eof[base+k] !== int'(e[EW-1]) || r_pix[base+k] !== ep) begin
            failures++;
            $display("FAIL vstep_res k=%0d got=(%0d,%0d) pix=%0d exp=(%0d,%0d) pix=%0d",
                     k, r_x[base+k], r_y[base+k], r_pix[base+k], e[XW-1:0], e[EW-2:XW], ep);
         end
         // 1020 >> 2 = 255 still saturates to 255
         e2 = {1'b0, e, DW'(ep)};
         if (base2 + k < r2_q.size()) begin
            checks++;
            if (r2_q[base2+k] !== e2) begin failures++; $display("FAIL vstep_s2 k=%0d got=%h exp=%h", k, r2_q[base2+k], e2); end
         end
      end
   endtask

   task automatic test_ramp();
      int base, base2, acc, n, m;
      logic [EW-1:0] e;
      logic [RW-1:0] e2;
      exp_q.delete(); add_full();
      base = r_x.size(); base2 = r2_q.size();
      send_frame(2, -1, -1, 1'b0, acc);
      idle(8);
      n = r_x.size() - base;
      m = (n < exp_q.size()) ? n : exp_q.size();
      checks++; if (n !== exp_q.size()) begin failures++; $display("FAIL ramp_count got=%0d exp=%0d", n, exp_q.size()); end
      checks++; if (r2_q.size() - base2 !== exp_q.size()) begin failures++; $display("FAIL ramp_count_s2 got=%0d exp=%0d", r2_q.size() - base2, exp_q.size()); end
      for (int k = 0; k < m; k++) begin
         e = exp_q[k];
         checks++;
         if (r_x[base+k] !== int'(e[XW-1:0]) || r_y[base+k] !== int'(e[EW-2:XW]) || r_pix[base+k] !== 80) begin
            failures++;
            $display("FAIL ramp_res k=%0d got=(%0d,%0d) pix=%0d exp=(%0d,%0d) pix=80",
                     k, r_x[base+k], r_y[base+k], r_pix[base+k], e[XW-1:0], e[EW-2:XW]);
         end
         e2 = {1'b0, e, 8'd20};
         if (base2 + k < r2_q.size()) begin
            checks++;
            if (r2_q[base2+k] !== e2) begin failures++; $display("FAIL ramp_s2 k=%0d got=%h exp=%h", k, r2_q[base2+k], e2); end
         end
      end
   endtask

   task automatic test_gap();
      int base, errb, acc, n, m;
      logic [EW-1:0] e;
      // gap where (3,2) would arrive: only pixel (2,2) ever completes a window
      base = r_x.size(); errb = err_cnt;
      send_frame(0, 3, 2, 1'b1, acc);
      idle(8);
      n = r_x.size() - base;
      checks++; if (n !== 1) begin failures++; $display("FAIL gap_count got=%0d exp=1", n); end
      if (n > 0) begin
         checks++;
         if (r_x[base] !== 1 || r_y[base] !== 1 || r_pix[base] !== 0 || r_eof[base] !== 0) begin
            failures++;
            $display("FAIL gap_res got=(%0d,%0d) pix=%0d eof=%0d exp=(1,1) pix=0 eof=0", r_x[base], r_y[base], r_pix[base], r_eof[base]);
         end
      end
      checks++; if (err_cnt - errb !== 1) begin failures++; $display("FAIL gap_err_pulses got=%0d exp=1", err_cnt - errb); end
      // recovery frame
      exp_q.delete(); add_full();
      base = r_x.size(); errb = err_cnt;
      send_frame(1, -1, -1, 1'b0, acc);
      idle(8);
      n = r_x.size() - base;
      m = (n < exp_q.size()) ? n : exp_q.size();
      checks++; if (n !== exp_q.size()) begin failures++; $display("FAIL gap_recover_count got=%0d exp=%0d", n, exp_q.size()); end
      checks++; if (err_cnt !== errb) begin failures++; $display("FAIL gap_recover_err got=%0d exp=0", err_cnt - errb); end
      for (int k = 0; k < m; k++) begin
         e = exp_q[k];
         checks++;
         if (r_x[base+k] !== int'(e[XW-1:0]) || r_y[base+k] !== int'(e[EW-2:XW]) || r_eof[base+k] !== int'(e[EW-1]) ||
             r_pix[base+k] !== ((e[XW-1:0] == 3 || e[XW-1:0] == 4) ? 255 : 0)) begin
            failures++;
            $display("FAIL gap_recover_res k=%0d got=(%0d,%0d) pix=%0d eof=%0d exp=(%0d,%0d) eof=%0d",
                     k, r_x[base+k], r_y[base+k], r_pix[base+k], r_eof[base+k], e[XW-1:0], e[EW-2:XW], e[EW-1]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int base, acc, n, m;
      logic [EW-1:0] e;
      send_frame(1, 3, 4, 1'b0, acc);
      // results are still streaming out here; reset lands between edges
      #2;
      rst_n = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
      checks++; if (out_pix !== '0 || out_x !== '0 || out_y !== '0 || out_eof !== 1'b0) begin
         failures++; $display("FAIL rstmid_outs got=pix %0d (%0d,%0d) eof %b exp=all 0", out_pix, out_x, out_y, out_eof);
      end
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);
      exp_q.delete(); add_full();
      base = r_x.size();
      send_frame(0, -1, -1, 1'b0, acc);
      idle(8);
      n = r_x.size() - base;
      m = (n < exp_q.size()) ? n : exp_q.size();
      checks++; if (n !== exp_q.size()) begin failures++; $display("FAIL rstmid_count got=%0d exp=%0d", n, exp_q.size()); end
      for (int k = 0; k < m; k++) begin
         e = exp_q[k];
         checks++;
         if (r_x[base+k] !== int'(e[XW-1:0]) || r_y[base+k] !== int'(e[EW-2:XW]) ||
             r_eof[base+k] !== int'(e[EW-1]) || r_pix[base+k] !== 0) begin
            failures++;
            $display("FAIL rstmid_res k=%0d got=(%0d,%0d) pix=%0d exp=(%0d,%0d) pix=0", k, r_x[base+k], r_y[base+k], r_pix[base+k], e[XW-1:0], e[EW-2:XW]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int base, base2, errb, acc, n, m;
      logic [EW-1:0] e;
      logic [RW-1:0] e2;
      // A and B back to back, C cut by a new sof at (5,3), then D
      exp_q.delete();
      add_full(); add_full();
      for (int x = 1; x <= 6; x++) add_c(x, 1, 1'b0);
      for (int x = 1; x <= 3; x++) add_c(x, 2, 1'b0);
      add_full();
      base = r_x.size(); base2 = r2_q.size(); errb = err_cnt;
      send_frame(2, -1, -1, 1'b0, acc);
      send_frame(2, -1, -1, 1'b0, acc);
      send_frame(2, 5, 3, 1'b0, acc);
      send_frame(2, -1, -1, 1'b0, acc);
      idle(8);
      n = r_x.size() - base;
      m = (n < exp_q.size()) ? n : exp_q.size();
      checks++; if (n !== exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", n, exp_q.size()); end
      checks++; if (err_cnt !== errb) begin failures++; $display("FAIL b2b_err got=%0d exp=0", err_cnt - errb); end
      for (int k = 0; k < m; k++) begin
         e = exp_q[k];
         checks++;
         if (r_x[base+k] !== int'(e[XW-1:0]) || r_y[base+k] !== int'(e[EW-2:XW]) ||
             r_eof[base+k] !== int'(e[EW-1]) || r_pix[base+k] !== 80) begin
            failures++;
            $display("FAIL b2b_res k=%0d got=(%0d,%0d) pix=%0d eof=%0d exp=(%0d,%0d) pix=80 eof=%0d",
                     k, r_x[base+k], r_y[base+k], r_pix[base+k], r_eof[base+k], e[XW-1:0], e[EW-2:XW], e[EW-1]);
         end
         e2 = {1'b0, e, 8'd20};
         if (base2 + k < r2_q.size()) begin
            checks++;
            if (r2_q[base2+k] !== e2) begin failures++; $display("FAIL b2b_s2 k=%0d got=%h exp=%h", k, r2_q[base2+k], e2); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_flat();
      test_vstep();
      test_ramp();
      test_gap();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
